instr_control_unit: RTL and testbench

- Hardwired control sequencer for the 32-bit bus datapath.
- Generates every bus-drive, register-load, memory and ALU control strobe that the datapath consumes.
- Runs the instruction fetch (T0–T2) and register-register ALU execute (T3–T5) sequence, taking the opcode and register fields from the IR.
- Sits beside the datapath, which feeds the IR contents and a memory-ready handshake back to it.

---
 rtl/instr_control_unit_if.sv | 39 +++
 rtl/instr_control_unit.sv | 175 +++++++++++++++++
 tb/tb_instr_control_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instr_control_unit_if.sv
// Purpose : datapath-facing bundle of the control sequencer: IR and memory-ready
//           come back from the datapath, every bus/register/ALU/memory strobe goes out.
// Ports   : master = sequencer side (drives strobes), slave = datapath side.
interface instr_control_unit_if;
  logic [31:0] ir;         // current IR contents
  logic        mem_ready;  // memory read data valid on Mdatain

  // bus drive enables
  logic        PCout;
  logic        Zlowout;
  logic        MDRout;
  // register load enables
  logic        MARin;
  logic        Zin;
  logic        PCin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  // ALU / memory control
  logic        IncPC;
  logic        read;
  logic [3:0]  alu_op;     // one-hot {OR,AND,SUB,ADD}
  // GP register file access
  logic        reg_out;
  logic        reg_in;
  logic [3:0]  reg_sel;

  modport master (
    input  ir, mem_ready,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncPC, read, alu_op, reg_out, reg_in, reg_sel
  );

  modport slave (
    output ir, mem_ready,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncPC, read, alu_op, reg_out, reg_in, reg_sel
  );
endinterface

// File: rtl/instr_control_unit.sv
// Purpose : hardwired fetch (T0-T2) / reg-reg ALU execute (T3-T5) sequencer for the 32-bit bus datapath.
// Latency : 6 cycles per ALU instruction, +1 per cycle mem_ready is low in T1; strobes are Moore outputs.
// Backpr. : T1 holds (strobes asserted) until mem_ready=1; run only sampled at instruction boundaries.
// Ports   : clk, reset_n (async active-low), run (level), bus (master modport: ir/mem_ready in,
//           strobes out), halted, illegal_op (one-cycle pulse in T3), instr_count (retired ALU ops).
module instr_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  instr_control_unit_if.master bus,
  output logic                 halted,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [4:0] OP_ADD  = 5'b01001;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  // Reset is asserted asynchronously but released through two flops, so the
  // sequencer never leaves IDLE on the same edge that reset_n deasserts near.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  assign rst_meta_d = 1'b1;
  assign rst_sync_d = rst_meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q       <= S_IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // IR field decode
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu;
  logic [3:0] alu_onehot;
  logic       unused_ir_bits;

  assign opcode         = bus.ir[31:27];
  assign ra             = bus.ir[26:23];
  assign rb             = bus.ir[22:19];
  assign rc             = bus.ir[18:15];
  assign unused_ir_bits = ^bus.ir[14:0];

  always_comb begin
    is_alu     = 1'b1;
    alu_onehot = 4'b0000;
    unique case (opcode)
      OP_ADD:  alu_onehot = 4'b0001;
      OP_SUB:  alu_onehot = 4'b0010;
      OP_AND:  alu_onehot = 4'b0100;
      OP_OR:   alu_onehot = 4'b1000;
      default: is_alu = 1'b0;
    endcase
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;

    bus.PCout   = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.MARin   = 1'b0;
    bus.Zin     = 1'b0;
    bus.PCin    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.IncPC   = 1'b0;
    bus.read    = 1'b0;
    bus.alu_op  = 4'b0000;
    bus.reg_out = 1'b0;
    bus.reg_in  = 1'b0;
    bus.reg_sel = 4'd0;
    halted      = 1'b0;
    illegal_op  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = S_T1;
      end
      S_T1: begin
        // Held while memory is not ready; re-loading PC from Z is idempotent.
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (bus.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          bus.reg_out = 1'b1;
          bus.reg_sel = rb;
          bus.Yin     = 1'b1;
          state_d     = S_T4;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          // Undefined opcode: skip execute, no register traffic this cycle.
          illegal_op = 1'b1;
          state_d    = run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        bus.reg_out = 1'b1;
        bus.reg_sel = rc;
        bus.alu_op  = alu_onehot;
        bus.Zin     = 1'b1;
        state_d     = S_T5;
      end
      S_T5: begin
        bus.Zlowout   = 1'b1;
        bus.reg_in    = 1'b1;
        bus.reg_sel   = ra;
        instr_count_d = instr_count_q + 1'b1;  // wraps naturally
        state_d       = run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_control_unit.sv
// Purpose : directed self-checking bench for instr_control_unit (CNT_W=4 so the counter wrap is reachable).
// Latency : checks every state cycle by cycle, sampling 1 time unit after each rising edge.
// Backpr. : exercises mem_ready stalls in T1 and run deassertion at instruction boundaries.
module tb_instr_control_unit;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic       halted;
  logic       illegal_op;
  logic [3:0] instr_count;

  instr_control_unit_if dp_if ();

  instr_control_unit #(.CNT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .bus         (dp_if),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_cnt = 4'd0;

  typedef struct {
    logic [31:0] ir;
    int          kind;   // 0 = ALU, 1 = illegal, 2 = HALT
    logic [3:0]  aop;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {PCout,Zlowout,MDRout,MARin,Zin,PCin,MDRin,IRin,Yin,IncPC,read,reg_out,reg_in,alu_op,reg_sel,halted,illegal_op}
  function automatic logic [22:0] obs();
    return {dp_if.PCout, dp_if.Zlowout, dp_if.MDRout, dp_if.MARin, dp_if.Zin, dp_if.PCin,
            dp_if.MDRin, dp_if.IRin, dp_if.Yin, dp_if.IncPC, dp_if.read, dp_if.reg_out,
            dp_if.reg_in, dp_if.alu_op, dp_if.reg_sel, halted, illegal_op};
  endfunction

  // Expected strobe set: t = 0..5 for T0..T5, 6 = illegal T3, 7 = HALT, other = all zero.
  function automatic logic [22:0] ev(input int t, input logic [3:0] aop, input logic [3:0] rs);
    logic pco, zlo, mdro, mari, zi, pci, mdri, iri, yi, inc, rd, ro, ri, hl, il;
    logic [3:0] ao, sel;
    {pco, zlo, mdro, mari, zi, pci, mdri, iri, yi, inc, rd, ro, ri, hl, il} = '0;
    ao  = 4'd0;
    sel = 4'd0;
    case (t)
      0: begin pco = 1; mari = 1; inc = 1; zi = 1; end
      1: begin zlo = 1; pci = 1; rd = 1; mdri = 1; end
      2: begin mdro = 1; iri = 1; end
      3: begin ro = 1; sel = rs; yi = 1; end
      4: begin ro = 1; sel = rs; ao = aop; zi = 1; end
      5: begin zlo = 1; ri = 1; sel = rs; end
      6: il = 1;
      7: hl = 1;
      default: ;
    endcase
    return {pco, zlo, mdro, mari, zi, pci, mdri, iri, yi, inc, rd, ro, ri, ao, sel, hl, il};
  endfunction

  // After reset release: nothing in the first cycle, then T0 within a bounded number of edges.
  task automatic wait_t0();
    tick();
    check("no_early_strobes", 32'(obs()), 32'(ev(9, 4'd0, 4'd0)));
    for (int i = 0; i < 8 && !dp_if.PCout; i++) tick();
    check("reach_t0", 32'(dp_if.PCout), 32'd1);
  endtask

  // Entered with the DUT sampled in T0. mode: 0 normal, 1 drop run in T3, 2 reset in T4.
  task automatic run_instr(input int idx, input int stall, input int mode);
    vec_t v;
    v = tbl[idx];
    check("t0", 32'(obs()), 32'(ev(0, 4'd0, 4'd0)));
    tick();
    for (int k = 0; k <= stall; k++) begin
      check("t1", 32'(obs()), 32'(ev(1, 4'd0, 4'd0)));
      dp_if.mem_ready = (k == stall);
      tick();
    end
    dp_if.mem_ready = 1'b1;
    check("t2", 32'(obs()), 32'(ev(2, 4'd0, 4'd0)));
    dp_if.ir = v.ir;  // IR value loaded at the end of T2
    tick();
    if (v.kind == 0) begin
      check("t3", 32'(obs()), 32'(ev(3, 4'd0, v.rb)));
      if (mode == 1) run = 1'b0;
      tick();
      check("t4", 32'(obs()), 32'(ev(4, v.aop, v.rc)));
      if (mode == 2) begin
        reset_n = 1'b0;
        #1;
        check("rst_outputs", 32'(obs()), 32'(ev(9, 4'd0, 4'd0)));
        check("rst_count", 32'(instr_count), 32'd0);
        exp_cnt = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_t0();
        return;
      end
      tick();
      check("t5", 32'(obs()), 32'(ev(5, 4'd0, v.ra)));
      check("cnt_before_exit", 32'(instr_count), 32'(exp_cnt));
      tick();
      exp_cnt = exp_cnt + 4'd1;
      check("cnt_after_exit", 32'(instr_count), 32'(exp_cnt));
      if (mode == 1) begin
        check("idle_after_drop", 32'(obs()), 32'(ev(9, 4'd0, 4'd0)));
        tick();
        check("idle_hold", 32'(obs()), 32'(ev(9, 4'd0, 4'd0)));
        run = 1'b1;
        tick();
        check("t0_after_rerun", 32'(dp_if.PCout), 32'd1);
      end
    end else if (v.kind == 1) begin
      check("t3_illegal", 32'(obs()), 32'(ev(6, 4'd0, 4'd0)));
      tick();
      check("illegal_pulse_end", 32'(illegal_op), 32'd0);
      check("illegal_next_t0", 32'(dp_if.PCout), 32'd1);
      check("illegal_cnt", 32'(instr_count), 32'(exp_cnt));
    end else begin
      tick();
      for (int k = 0; k < 6; k++) begin
        run = k[0];
        check("halt_state", 32'(obs()), 32'(ev(7, 4'd0, 4'd0)));
        check("halt_cnt", 32'(instr_count), 32'(exp_cnt));
        tick();
      end
    end
  endtask

  initial begin
    // ADD R5,R2,R4 / SUB R3,R1,R7 / AND R1,R6,R9 / OR R15,R0,R12 / opcode 00000 / HALT
    tbl[0] = '{32'h4A92_0000, 0, 4'b0001, 4'd5,  4'd2, 4'd4};
    tbl[1] = '{32'h518B_8000, 0, 4'b0010, 4'd3,  4'd1, 4'd7};
    tbl[2] = '{32'h58B4_8000, 0, 4'b0100, 4'd1,  4'd6, 4'd9};
    tbl[3] = '{32'h6786_0000, 0, 4'b1000, 4'd15, 4'd0, 4'd12};
    tbl[4] = '{32'h0000_0000, 1, 4'b0000, 4'd0,  4'd0, 4'd0};
    tbl[5] = '{32'hF800_0000, 2, 4'b0000, 4'd0,  4'd0, 4'd0};

    reset_n         = 1'b1;
    run             = 1'b0;
    dp_if.ir        = 32'h0;
    dp_if.mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    check("reset_outputs", 32'(obs()), 32'(ev(9, 4'd0, 4'd0)));
    check("reset_count", 32'(instr_count), 32'd0);

    tick();
    reset_n = 1'b1;
    run     = 1'b1;
    wait_t0();

    run_instr(0, 0, 0);  // ADD, no stall        -> count 1
    run_instr(0, 3, 0);  // ADD, 3 stall cycles  -> count 2
    run_instr(1, 0, 0);  // SUB
    run_instr(2, 0, 0);  // AND
    run_instr(3, 1, 0);  // OR with one stall
    run_instr(4, 0, 0);  // illegal, count unchanged
    run_instr(0, 0, 1);  // run dropped in T3
    run_instr(0, 0, 2);  // reset in T4 -> count 0
    for (int i = 0; i < 16; i++) run_instr(0, 0, 0);  // 15 -> 0 wrap on the 16th
    check("wrap_to_zero", 32'(instr_count), 32'd0);
    run_instr(5, 0, 0);  // HALT

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
